// File: rtl/gate_test_sequencer.sv
`default_nettype none
// gate_test_sequencer: loads an expected truth table from the host, walks every input vector
// through an external gate, and streams one result byte per vector back. Rev 1.0
module gate_test_sequencer #(
  parameter int N_IN          = 2,
  parameter int N_OUT         = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_byte,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count
);

  localparam int NUM_VEC = 1 << N_IN;
  localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int FAIL_W  = N_IN + 1;
  localparam logic [N_IN-1:0]   LAST_VEC    = N_IN'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(NUM_VEC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    SEND   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  load_idx;
  logic [N_IN-1:0]  vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [N_OUT-1:0] exp_mem [NUM_VEC];
  logic             mismatch;
  logic             unused_rx_bits;

  // Only the low N_OUT bits of a host byte carry the expected response.
  assign unused_rx_bits = ^rx_byte[7:N_OUT];
  assign mismatch       = (dut_out != exp_mem[vec]);

  always_ff @(posedge clk) begin
    if (state == LOAD && rx_valid) begin
      exp_mem[load_idx] <= rx_byte[N_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_idx   <= '0;
      vec        <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      tx_valid   <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
    end else if (abort) begin
      // fail_count is deliberately kept so the host can inspect a cancelled run.
      state    <= IDLE;
      dut_in   <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            load_idx   <= '0;
            fail_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            load_idx <= load_idx + 1'b1;
            if (load_idx == LAST_VEC) begin
              state      <= SETTLE;
              vec        <= '0;
              dut_in     <= '0;
              settle_cnt <= '0;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch && fail_count != FAIL_MAX) begin
            fail_count <= fail_count + 1'b1;
          end
          tx_byte  <= {mismatch, 7'(dut_out)};
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_count == '0);
            end else begin
              vec        <= vec + 1'b1;
              dut_in     <= vec + 1'b1;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`default_nettype none
// tb_gate_test_sequencer: randomized scoreboard bench with a gate model of adjustable latency.
// Rev 1.0
module tb_gate_test_sequencer;

  localparam int N_IN          = 2;
  localparam int N_OUT         = 1;
  localparam int SETTLE_CYCLES = 4;
  localparam int NUM_VEC       = 1 << N_IN;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic [N_OUT-1:0] dut_out;
  logic [N_IN-1:0]  dut_in;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_byte;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    fail_count;

  gate_test_sequencer #(
    .N_IN(N_IN),
    .N_OUT(N_OUT),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .dut_out(dut_out),
    .dut_in(dut_in),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_byte(tx_byte),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Gate under test: truth table dut_tt, whose output follows a change of dut_in only
  // once 'lat' rising edges have passed since that change.
  logic [N_OUT-1:0] dut_tt  [NUM_VEC];
  logic [N_OUT-1:0] exp_tab [NUM_VEC];
  int               lat     = 0;
  int               edges   = 1000;
  logic [N_IN-1:0]  last_in = '0;
  logic [N_IN-1:0]  prev_in = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (dut_in !== last_in) begin
      prev_in = last_in;
      last_in = dut_in;
      edges   = 0;
    end else if (edges < 1000) begin
      edges++;
    end
  end

  assign dut_out = (edges >= lat) ? dut_tt[last_in] : dut_tt[prev_in];

  int ready_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      tx_ready = 1'b1;
    else if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
  end

  int              passed = 0;
  int              total  = 0;
  int              exp_fails;
  int              n;
  logic [7:0]      held;
  logic [7:0]      sb_byte [$];
  logic [N_IN-1:0] sb_vec  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      check("tx_expected", 32'(sb_byte.size() > 0), 1);
      if (sb_byte.size() > 0) begin
        check("tx_byte", 32'(tx_byte), 32'(sb_byte.pop_front()));
        check("tx_vector", 32'(dut_in), 32'(sb_vec.pop_front()));
      end
    end
  end

  task automatic set_and();
    logic [N_IN-1:0] vv;
    for (int v = 0; v < NUM_VEC; v++) begin
      vv         = N_IN'(v);
      exp_tab[v] = N_OUT'(&vv);
      dut_tt[v]  = N_OUT'(&vv);
    end
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  // Predict the first npush result bytes, then start a run and upload the table.
  task automatic begin_run(input int npush, input int rmode);
    logic [N_OUT-1:0] cap;
    logic [N_IN-1:0]  pv;
    logic [7:0]       b;
    logic             mis;
    ready_mode = rmode;
    if (rmode == 2) tx_ready = 1'b0;
    exp_fails = 0;
    for (int v = 0; v < npush; v++) begin
      // A gate slower than the settle window still shows the previous vector's answer;
      // such runs always begin from dut_in = 0.
      pv  = (v == 0) ? '0 : N_IN'(v - 1);
      cap = (lat > SETTLE_CYCLES) ? dut_tt[pv] : dut_tt[N_IN'(v)];
      mis = (cap != exp_tab[v]);
      exp_fails += int'(mis);
      sb_byte.push_back({mis, 7'(cap)});
      sb_vec.push_back(N_IN'(v));
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_clears", 32'({busy, done, pass, fail_count}), 32'({1'b1, 1'b0, 1'b0, {(N_IN+1){1'b0}}}));
    for (int i = 0; i < NUM_VEC; ) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
      end else begin
        b[N_OUT-1:0] = exp_tab[i];
        rx_valid     = 1'b1;
        i++;
      end
      rx_byte = b;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  // Wait for completion while throwing ignored start/rx traffic at the busy sequencer.
  task automatic end_run(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 3000) begin
      @(posedge clk);
      #1;
      start    = busy && !tx_valid && ($urandom_range(0, 7) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_byte  = 8'($urandom);
      @(negedge clk);
      k++;
    end
    start    = 1'b0;
    rx_valid = 1'b0;
    check($sformatf("%s_done", tag), 32'(done), 1);
    check($sformatf("%s_pass", tag), 32'(pass), 32'(exp_fails == 0));
    check($sformatf("%s_fail_count", tag), 32'(fail_count), 32'(exp_fails));
    check($sformatf("%s_idle", tag), 32'({busy, tx_valid}), 0);
    check($sformatf("%s_last_vec", tag), 32'(dut_in), NUM_VEC - 1);
    check($sformatf("%s_sb_empty", tag), 32'(sb_byte.size()), 0);
    repeat (3) @(negedge clk);
    check($sformatf("%s_done_hold", tag), 32'({done, pass}), 32'({1'b1, exp_fails == 0}));
    sb_byte.delete();
    sb_vec.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 300000", $time);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = '0;
    tx_ready = 1'b0;
    for (int v = 0; v < NUM_VEC; v++) begin
      dut_tt[v]  = '0;
      exp_tab[v] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({dut_in, tx_valid, tx_byte, busy, done, pass, fail_count}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", 32'({busy, done, tx_valid}), 0);

    // AND gate against a matching table, then the same table with a stuck-at-0 gate.
    set_and();
    begin_run(NUM_VEC, 0);
    end_run("and_ok");
    for (int v = 0; v < NUM_VEC; v++) dut_tt[v] = '0;
    begin_run(NUM_VEC, 0);
    end_run("stuck0");

    // Reset in the middle of a table upload.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", 32'({dut_in, tx_valid, tx_byte, busy, done, pass, fail_count}), 0);
    @(posedge clk);
    #1 check("rst_held", 32'({dut_in, tx_valid, tx_byte, busy, done, pass, fail_count}), 0);
    rst = 1'b0;
    set_and();
    begin_run(NUM_VEC, 0);
    end_run("after_rst");

    // Host stalls the result of vector 1 for ten cycles; stuck-at-1 gate makes it 0x81.
    for (int v = 0; v < NUM_VEC; v++) dut_tt[v] = '1;
    begin_run(NUM_VEC, 2);
    for (int v = 0; v < NUM_VEC; v++) begin
      n = 0;
      @(negedge clk);
      while (tx_valid !== 1'b1 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("stall_tx_valid", 32'(tx_valid), 1);
      if (v == 1) begin
        held = tx_byte;
        repeat (10) begin
          @(negedge clk);
          check("stall_hold", 32'({tx_valid, tx_byte, dut_in}), 32'({1'b1, held, N_IN'(1)}));
        end
      end
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    end_run("stall");

    // Gate latency exactly at, then one edge beyond, the capture point.
    for (int v = 0; v < NUM_VEC; v++) begin
      dut_tt[v]  = N_OUT'(v & 1);
      exp_tab[v] = N_OUT'($urandom);
    end
    pulse_abort();
    lat = SETTLE_CYCLES;
    begin_run(NUM_VEC, 1);
    end_run("lat_edge");
    pulse_abort();
    check("abort_from_done", 32'({done, pass, busy, dut_in}), 0);
    lat = SETTLE_CYCLES + 1;
    begin_run(NUM_VEC, 1);
    end_run("lat_late");
    lat = 0;

    // Abort (with a simultaneous start) while settling vector 2.
    set_and();
    for (int v = 0; v < NUM_VEC; v++) dut_tt[v] = '1;
    begin_run(2, 0);
    n = 0;
    @(negedge clk);
    while (!(busy === 1'b1 && tx_valid === 1'b0 && dut_in == N_IN'(2)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_vec2", 32'(dut_in), 2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_outputs", 32'({busy, dut_in, tx_valid, done, pass}), 0);
    check("abort_keeps_fail_count", 32'(fail_count), 32'(exp_fails));
    repeat (3) @(negedge clk);
    check("abort_start_discarded", 32'({busy, done}), 0);
    check("abort_sb_empty", 32'(sb_byte.size()), 0);
    sb_byte.delete();
    sb_vec.delete();
    set_and();
    begin_run(NUM_VEC, 0);
    end_run("after_abort");

    // Every vector mismatches: fail_count reaches 2^N_IN.
    for (int v = 0; v < NUM_VEC; v++) begin
      dut_tt[v]  = N_OUT'($urandom);
      exp_tab[v] = ~dut_tt[v];
    end
    begin_run(NUM_VEC, 1);
    end_run("all_fail");

    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < NUM_VEC; v++) begin
        dut_tt[v]  = N_OUT'($urandom);
        exp_tab[v] = N_OUT'($urandom);
      end
      begin_run(NUM_VEC, int'($urandom_range(0, 1)));
      end_run($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
